traffic_light_monitor: RTL and testbench

- Passive checker on the receiving end of the 3-bit one-hot light interface driven by the traffic light controller.
- Samples the light bus every clock. Checks encoding, phase order (RED->GREEN->YELLOW->RED) and per-phase dwell time against parameters.
- Reports each violation as a one-cycle pulse with an error code, and keeps a saturating error count.
- Sits beside the controller in the intersection subsystem, feeding status/interrupt logic and the verification scoreboard.

---
 rtl/traffic_light_pkg.sv | 54 +++++
 rtl/tl_sat_counter.sv | 22 ++
 rtl/traffic_light_monitor.sv | 146 ++++++++++++++
 tb/tb_traffic_light_monitor.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the traffic light controller and its monitor.
package traffic_light_pkg;

  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } light_t;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_GREEN  = 3'b010;
  localparam logic [2:0] LIGHT_YELLOW = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    TRACK = 2'd2
  } mon_state_t;

  typedef enum logic [2:0] {
    ERR_NONE        = 3'd0,
    ERR_ILLEGAL_ENC = 3'd1,
    ERR_BAD_SEQ     = 3'd2,
    ERR_SHORT_DWELL = 3'd3,
    ERR_LONG_DWELL  = 3'd4
  } err_code_t;

  localparam int unsigned DEF_RED_CYCLES    = 10;
  localparam int unsigned DEF_GREEN_CYCLES  = 10;
  localparam int unsigned DEF_YELLOW_CYCLES = 3;

  function automatic light_t next_phase(input light_t p);
    case (p)
      RED:     return GREEN;
      GREEN:   return YELLOW;
      YELLOW:  return RED;
      default: return RED;
    endcase
  endfunction

  function automatic logic is_legal(input logic [2:0] l);
    return (l == LIGHT_RED) || (l == LIGHT_GREEN) || (l == LIGHT_YELLOW);
  endfunction

  // Only meaningful for legal one-hot codes.
  function automatic light_t decode(input logic [2:0] l);
    case (l)
      LIGHT_GREEN:  return GREEN;
      LIGHT_YELLOW: return YELLOW;
      default:      return RED;
    endcase
  endfunction

endpackage

// File: rtl/tl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment yields 1.
module tl_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  // Count events, stick at all-ones, clear takes precedence over the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= inc ? W'(1) : '0;
    else if (inc && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Passive checker for the one-hot light bus: encoding, phase order and dwell time.
import traffic_light_pkg::*;

module traffic_light_monitor #(
  parameter int unsigned RED_CYCLES    = DEF_RED_CYCLES,
  parameter int unsigned GREEN_CYCLES  = DEF_GREEN_CYCLES,
  parameter int unsigned YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned ERRCNT_W      = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr_err,
  input  logic [2:0]          light_in,
  output logic                locked,
  output logic                err_pulse,
  output logic [2:0]          err_code,
  output logic [ERRCNT_W-1:0] err_count,
  output light_t              phase
);

  mon_state_t       state, state_n;
  logic [2:0]       prev_light;
  logic [CNT_W-1:0] dwell, dwell_n, expected;
  light_t           phase_n;
  logic             locked_n, err_n;
  err_code_t        code_n;
  logic             changed, new_legal, prev_legal, succ;

  // Required dwell for the phase currently being tracked.
  always_comb begin
    case (phase)
      GREEN:   expected = CNT_W'(GREEN_CYCLES);
      YELLOW:  expected = CNT_W'(YELLOW_CYCLES);
      default: expected = CNT_W'(RED_CYCLES);
    endcase
  end

  // Next-state, dwell tracking and violation classification.
  always_comb begin
    state_n    = state;
    dwell_n    = dwell;
    phase_n    = phase;
    locked_n   = locked;
    err_n      = 1'b0;
    code_n     = ERR_NONE;
    changed    = (light_in != prev_light);
    new_legal  = is_legal(light_in);
    prev_legal = is_legal(prev_light);
    succ       = new_legal && prev_legal &&
                 (decode(light_in) == next_phase(decode(prev_light)));

    if (!en) begin
      state_n  = IDLE;
      locked_n = 1'b0;
      dwell_n  = '0;
    end else begin
      case (state)
        IDLE: state_n = SYNC;
        SYNC: begin
          // Dwell is unknown here; a change from an illegal code is not a sequence error.
          if (changed) begin
            if (!new_legal) begin
              err_n  = 1'b1;
              code_n = ERR_ILLEGAL_ENC;
            end else if (prev_legal && !succ) begin
              err_n  = 1'b1;
              code_n = ERR_BAD_SEQ;
            end else if (succ) begin
              state_n  = TRACK;
              dwell_n  = CNT_W'(1);
              phase_n  = decode(light_in);
              locked_n = 1'b1;
            end
          end
        end
        TRACK: begin
          if (!changed) begin
            if (dwell == expected) begin
              err_n    = 1'b1;
              code_n   = ERR_LONG_DWELL;
              state_n  = SYNC;
              locked_n = 1'b0;
            end else begin
              dwell_n = dwell + CNT_W'(1);
            end
          end else begin
            if (!new_legal) begin
              err_n  = 1'b1;
              code_n = ERR_ILLEGAL_ENC;
            end else if (!succ) begin
              err_n  = 1'b1;
              code_n = ERR_BAD_SEQ;
            end else if (dwell < expected) begin
              err_n  = 1'b1;
              code_n = ERR_SHORT_DWELL;
            end
            if (err_n) begin
              state_n  = SYNC;
              locked_n = 1'b0;
            end else begin
              dwell_n = CNT_W'(1);
              phase_n = decode(light_in);
            end
          end
        end
        default: begin
          state_n  = IDLE;
          locked_n = 1'b0;
        end
      endcase
    end
  end

  // Registered state and outputs; prev_light always follows the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      prev_light <= LIGHT_RED;
      dwell      <= '0;
      phase      <= RED;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      state      <= state_n;
      prev_light <= light_in;
      dwell      <= dwell_n;
      phase      <= phase_n;
      locked     <= locked_n;
      err_pulse  <= err_n;
      if (err_n)
        err_code <= code_n;
    end
  end

  tl_sat_counter #(.W(ERRCNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (err_n),
    .clr   (clr_err),
    .count (err_count)
  );

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench: stimulus pushes expected violations, a monitor pops them on each err_pulse.
import traffic_light_pkg::*;

module tb_traffic_light_monitor;

  logic       clk, rst, en, clr_err;
  logic [2:0] light_in;
  logic       locked, err_pulse;
  logic [2:0] err_code;
  logic [7:0] err_count;
  light_t     phase;

  typedef struct {
    logic [2:0]  code;
    logic [7:0]  cnt;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc;
  int unsigned checks, errors;
  logic [7:0]  exp_cnt;

  traffic_light_monitor #(
    .RED_CYCLES(10), .GREEN_CYCLES(10), .YELLOW_CYCLES(3), .CNT_W(8), .ERRCNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .clr_err(clr_err), .light_in(light_in),
    .locked(locked), .err_pulse(err_pulse), .err_code(err_code),
    .err_count(err_count), .phase(phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at cycle %0d", name, got, want, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest expected violation.
  always @(negedge clk) begin
    if (!rst && err_pulse) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse code=%0d count=%0d at cycle %0d", err_code, err_count, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_code", int'(err_code), int'(e.code));
        chk("pulse_count", int'(err_count), int'(e.cnt));
        chk("pulse_cycle", int'(cyc), int'(e.cyc));
      end
    end
  end

  // One sample: drive at negedge, record any expected violation, settle after posedge.
  task automatic step(input logic [2:0] l, input logic [2:0] code, input logic clr);
    exp_t e;
    @(negedge clk);
    light_in = l;
    clr_err  = clr;
    if (clr)
      exp_cnt = (code != 3'd0) ? 8'd1 : 8'd0;
    else if ((code != 3'd0) && (exp_cnt != 8'hFF))
      exp_cnt = exp_cnt + 8'd1;
    if (code != 3'd0) begin
      e.code = code;
      e.cnt  = exp_cnt;
      e.cyc  = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [2:0] l, input int n);
    for (int i = 0; i < n; i++) step(l, ERR_NONE, 1'b0);
  endtask

  task automatic chk_reset_values();
    chk("rst_locked", int'(locked), 0);
    chk("rst_pulse", int'(err_pulse), 0);
    chk("rst_code", int'(err_code), 0);
    chk("rst_count", int'(err_count), 0);
    chk("rst_phase", int'(phase), int'(RED));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0; cyc = 0; exp_cnt = 8'd0;
    rst = 1'b1; en = 1'b0; clr_err = 1'b0; light_in = LIGHT_RED;
    #1;
    chk_reset_values();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Legal stream: locks on the first RED->GREEN and never complains.
    en = 1'b1;
    hold(LIGHT_RED, 10);
    chk("sync_unlocked", int'(locked), 0);
    hold(LIGHT_GREEN, 1);
    chk("first_lock", int'(locked), 1);
    chk("first_phase", int'(phase), int'(GREEN));
    hold(LIGHT_GREEN, 9);
    hold(LIGHT_YELLOW, 3);
    for (int r = 0; r < 2; r++) begin
      hold(LIGHT_RED, 10);
      hold(LIGHT_GREEN, 10);
      hold(LIGHT_YELLOW, 3);
    end
    hold(LIGHT_RED, 10);
    chk("legal_locked", int'(locked), 1);
    chk("legal_phase", int'(phase), int'(RED));
    chk("legal_count", int'(err_count), 0);

    // GREEN held 7 samples: short dwell, relock on YELLOW->RED.
    hold(LIGHT_GREEN, 7);
    step(LIGHT_YELLOW, ERR_SHORT_DWELL, 1'b0);
    chk("short_unlock", int'(locked), 0);
    chk("short_code", int'(err_code), 3);
    chk("short_count", int'(err_count), 1);
    hold(LIGHT_YELLOW, 2);
    step(LIGHT_RED, ERR_NONE, 1'b0);
    chk("relock", int'(locked), 1);

    // RED: 10 samples legal, 11th is long dwell, single pulse through 20 samples.
    hold(LIGHT_RED, 9);
    step(LIGHT_RED, ERR_LONG_DWELL, 1'b0);
    chk("long_code", int'(err_code), 4);
    chk("long_unlock", int'(locked), 0);
    hold(LIGHT_RED, 9);
    chk("long_count", int'(err_count), 2);

    // Illegal encodings, then wrong successor.
    step(3'b110, ERR_ILLEGAL_ENC, 1'b0);
    step(3'b110, ERR_NONE, 1'b0);
    step(LIGHT_RED, ERR_NONE, 1'b0);
    step(LIGHT_YELLOW, ERR_BAD_SEQ, 1'b0);
    chk("badseq_code", int'(err_code), 2);
    chk("badseq_count", int'(err_count), 4);
    step(3'b000, ERR_ILLEGAL_ENC, 1'b0);
    hold(3'b000, 3);
    step(LIGHT_GREEN, ERR_NONE, 1'b0);
    step(LIGHT_YELLOW, ERR_NONE, 1'b0);
    chk("lock_yellow", int'(locked), 1);
    chk("lock_yellow_phase", int'(phase), int'(YELLOW));
    step(3'b011, ERR_ILLEGAL_ENC, 1'b0);
    chk("illegal_over_short", int'(err_code), 1);
    step(LIGHT_RED, ERR_NONE, 1'b0);
    step(LIGHT_GREEN, ERR_NONE, 1'b0);
    step(LIGHT_RED, ERR_BAD_SEQ, 1'b0);
    chk("badseq_over_short", int'(err_code), 2);
    chk("prio_count", int'(err_count), 7);

    // Disabled: nothing is checked, code and count hold.
    en = 1'b0;
    step(3'b110, ERR_NONE, 1'b0);
    step(3'b000, ERR_NONE, 1'b0);
    step(LIGHT_YELLOW, ERR_NONE, 1'b0);
    chk("idle_locked", int'(locked), 0);
    chk("idle_code", int'(err_code), 2);
    chk("idle_count", int'(err_count), 7);

    // 300 alternating illegal codes: count saturates at 255.
    en = 1'b1;
    step(3'b000, ERR_NONE, 1'b0);
    for (int i = 0; i < 300; i++)
      step((i % 2 == 0) ? 3'b111 : 3'b000, ERR_ILLEGAL_ENC, 1'b0);
    chk("sat_count", int'(err_count), 255);
    step(3'b111, ERR_ILLEGAL_ENC, 1'b1);
    chk("clr_with_err", int'(err_count), 1);
    step(3'b111, ERR_NONE, 1'b1);
    chk("clr_only", int'(err_count), 0);

    // Lock on GREEN, then reset mid-phase.
    step(LIGHT_RED, ERR_NONE, 1'b0);
    step(LIGHT_GREEN, ERR_NONE, 1'b0);
    hold(LIGHT_GREEN, 4);
    chk("pre_rst_locked", int'(locked), 1);
    chk("sb_empty_pre_rst", sb.size(), 0);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_values();
    sb.delete();
    exp_cnt = 8'd0;
    @(negedge clk);
    rst = 1'b0;

    // Partial first phase after reset is not dwell-checked.
    hold(LIGHT_GREEN, 3);
    step(LIGHT_YELLOW, ERR_NONE, 1'b0);
    chk("post_rst_lock", int'(locked), 1);
    chk("post_rst_phase", int'(phase), int'(YELLOW));
    hold(LIGHT_YELLOW, 2);
    step(LIGHT_RED, ERR_NONE, 1'b0);
    chk("post_rst_red", int'(phase), int'(RED));
    chk("post_rst_count", int'(err_count), 0);

    @(negedge clk);
    chk("sb_empty_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
